// File: rtl/led_decoder.sv
// Registered hex-to-seven-segment decoder (abcdefg, LED[6]=a .. LED[0]=g).
// Optional blanking input is enabled by defining LED_DECODER_BLANK_EN.
module led_decoder #(
    parameter logic ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] char,
`ifdef LED_DECODER_BLANK_EN
    input  logic       blank,
`endif
    output logic [6:0] LED
);

    localparam logic [6:0] ALL_OFF = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    // Active-high segment pattern (lit = 1) for a hex digit.
    function automatic logic [6:0] hex_pattern(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            4'hF:    seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

    logic [6:0] w_lit;
    logic [6:0] w_next;
    logic [6:0] r_led;

    // Decode the current character and apply board polarity.
    always_comb begin
        w_lit  = hex_pattern(char);
        w_next = ALL_OFF;
`ifdef LED_DECODER_BLANK_EN
        if (blank) begin
            w_next = ALL_OFF;
        end else if (ACTIVE_LOW) begin
            w_next = ~w_lit;
        end else begin
            w_next = w_lit;
        end
`else
        if (ACTIVE_LOW) begin
            w_next = ~w_lit;
        end else begin
            w_next = w_lit;
        end
`endif
    end

    // Segment register: reset wins, otherwise load the decoded pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= ALL_OFF;
        end else begin
            r_led <= w_next;
        end
    end

    assign LED = r_led;

endmodule

// File: tb/tb_led_decoder.sv
// Self-checking bench for led_decoder: both polarities side by side,
// per-cycle model comparison plus hand-computed literal checks.
module tb_led_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       blank;
    logic [3:0] chr;
    logic [6:0] led_lo;
    logic [6:0] led_hi;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_decoder #(.ACTIVE_LOW(1'b1)) u_lo (
        .clk   (clk),
        .reset (reset),
        .char  (chr),
`ifdef LED_DECODER_BLANK_EN
        .blank (blank),
`endif
        .LED   (led_lo)
    );

    led_decoder #(.ACTIVE_LOW(1'b0)) u_hi (
        .clk   (clk),
        .reset (reset),
        .char  (chr),
`ifdef LED_DECODER_BLANK_EN
        .blank (blank),
`endif
        .LED   (led_hi)
    );

    // Digit shapes as drawn on the display, segments a..g, lit = 1.
    logic [6:0] shape [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [6:0] model(input logic r, input logic b,
                                         input logic [3:0] c, input logic al);
        logic [6:0] lit;
        lit = (r || b) ? 7'b0000000 : shape[c];
        return al ? ~lit : lit;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    logic [6:0] exp_lo;
    logic [6:0] exp_hi;
    logic       exp_valid = 1'b0;

    // Model: what each output must show after this edge.
    always @(posedge clk) begin
        exp_lo    <= model(reset, blank, chr, 1'b1);
        exp_hi    <= model(reset, blank, chr, 1'b0);
        exp_valid <= 1'b1;
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (exp_valid) begin
            check("model_lo", led_lo, exp_lo);
            check("model_hi", led_hi, exp_hi);
        end
    end

    initial begin
        reset = 1'b1;
        blank = 1'b0;
        chr   = 4'h8;
        repeat (2) @(posedge clk);
        #4;
        check("reset_lo", led_lo, 7'b1111111);
        check("reset_hi", led_hi, 7'b0000000);

        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chr = 4'(i);
            @(posedge clk);
            #4;
            if (i == 0)  check("sweep_0", led_lo, 7'b0000001);
            if (i == 2)  check("sweep_2", led_lo, 7'b0010010);
            if (i == 7)  check("sweep_7", led_lo, 7'b0001111);
            if (i == 8)  check("sweep_8", led_lo, 7'b0000000);
            if (i == 10) check("hi_A", led_hi, 7'b1110111);
        end

        chr = 4'h1;
        @(posedge clk);
        #4;
        check("lat_1", led_lo, 7'b1001111);
        chr = 4'h2;
        #2;
        check("lat_hold", led_lo, 7'b1001111);
        @(posedge clk);
        #4;
        check("lat_2", led_lo, 7'b0010010);

        chr = 4'h0;
        @(posedge clk);
        #4;
        reset = 1'b1;
        @(posedge clk);
        #4;
        check("midrst_lo", led_lo, 7'b1111111);
        check("midrst_hi", led_hi, 7'b0000000);
        reset = 1'b0;
        @(posedge clk);
        #4;
        check("release_lo", led_lo, 7'b0000001);
        check("release_hi", led_hi, 7'b1111110);

`ifdef LED_DECODER_BLANK_EN
        chr   = 4'h3;
        blank = 1'b1;
        @(posedge clk);
        #4;
        check("blank_on", led_lo, 7'b1111111);
        blank = 1'b0;
        @(posedge clk);
        #4;
        check("blank_off", led_lo, 7'b0000110);
        reset = 1'b1;
        blank = 1'b1;
        @(posedge clk);
        #4;
        check("blank_rst", led_lo, 7'b1111111);
        reset = 1'b0;
        blank = 1'b0;
`endif

        repeat (24) begin
            chr = 4'($urandom_range(0, 15));
            @(posedge clk);
            #4;
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
